// File: rtl/modulo_sequenciador_jk_pkg.sv
// Shared definitions for the JK-bank sequencer: command op codes, FSM state
// encodings and the JK cell next-state helper.
package modulo_sequenciador_jk_pkg;

    // Command op codes carried on cmd_op
    typedef enum logic [1:0] {
        OP_START = 2'b00,
        OP_STOP  = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    // Controller states, visible on the state output
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Classic JK behaviour: hold, reset, set, toggle
    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic r;
        case ({j, k})
            2'b00:   r = q;
            2'b01:   r = 1'b0;
            2'b10:   r = 1'b1;
            2'b11:   r = ~q;
            default: r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/modulo_sequenciador_jk_jk_bank.sv
// Bank of WIDTH JK flip-flop cells sharing clock, active-high synchronous
// reset and a common enable. Cells update on the falling clock edge.
module modulo_sequenciador_jk_jk_bank
    import modulo_sequenciador_jk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        logic q_q;

        // One JK cell: clear on reset, apply excitation only when enabled
        always_ff @(negedge clk) begin
            if (rst) begin
                q_q <= 1'b0;
            end else if (enable) begin
                q_q <= jk_next(q_q, j[g], k[g]);
            end else begin
                q_q <= q_q;
            end
        end

        assign q[g] = q_q;
    end

endmodule

// File: rtl/modulo_sequenciador_jk.sv
// Command-driven controller sequencing a JK flip-flop bank as a mod-MODULUS
// up/down counter. Accepts START/STOP/LOAD/CLEAR over valid/ready, derives
// per-bit J/K excitation and the bank enable, and pulses tc on each wrap.
// Optional build macro: SEQ_AUTORELOAD_EN keeps counting in RUN after a wrap
// instead of stopping in DONE.
module modulo_sequenciador_jk
    import modulo_sequenciador_jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic             step_en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec,
    output logic             busy,
    output logic             tc,
    output logic [1:0]       state
);

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic             dir_q, dir_d;
    logic             tc_q, tc_d;
    logic             ack_q, ack_d;

    logic             accept_s;
    logic             upd_s;
    logic             bank_en_s;
    logic [WIDTH-1:0] next_val_s;
    logic [WIDTH-1:0] load_val_s;

    // Ready drops for the cycle after any accepted command, and during reset
    assign cmd_ready = rst & ~ack_q;
    assign accept_s  = cmd_valid & cmd_ready;

    // The bank is only enabled on a real update and never while in reset
    assign bank_en_s = upd_s & rst;

    // Clamp a LOAD value into the legal count range
    always_comb begin
        if (32'(cmd_data) >= 32'(MODULUS)) begin
            load_val_s = MAX_COUNT;
        end else begin
            load_val_s = cmd_data;
        end
    end

    // FSM next-state, next count value and wrap detection; commands beat steps
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        tc_d       = 1'b0;
        ack_d      = accept_s;
        upd_s      = 1'b0;
        next_val_s = count;

        if (accept_s) begin
            case (op_e'(cmd_op))
                OP_START: begin
                    if (state_q != ST_RUN) begin
                        state_d = ST_RUN;
                        dir_d   = cmd_dir;
                    end else begin
                        state_d = state_q;
                    end
                end
                OP_STOP: begin
                    case (state_q)
                        ST_RUN:   state_d = ST_PAUSE;
                        ST_PAUSE: state_d = ST_IDLE;
                        ST_DONE:  state_d = ST_IDLE;
                        default:  state_d = state_q;
                    endcase
                end
                OP_LOAD: begin
                    if (state_q != ST_DONE) begin
                        upd_s      = 1'b1;
                        next_val_s = load_val_s;
                    end else begin
                        upd_s      = 1'b0;
                    end
                end
                OP_CLEAR: begin
                    state_d    = ST_IDLE;
                    upd_s      = 1'b1;
                    next_val_s = ZERO;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else if ((state_q == ST_RUN) && step_en) begin
            upd_s = 1'b1;
            if (dir_q) begin
                if (count == MAX_COUNT) begin
                    next_val_s = ZERO;
                    tc_d       = 1'b1;
                end else begin
                    next_val_s = count + ONE;
                end
            end else begin
                if (count == ZERO) begin
                    next_val_s = MAX_COUNT;
                    tc_d       = 1'b1;
                end else begin
                    next_val_s = count - ONE;
                end
            end
            if (tc_d) begin
`ifdef SEQ_AUTORELOAD_EN
                state_d = ST_RUN;
`else
                state_d = ST_DONE;
`endif
            end else begin
                state_d = state_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Controller registers, synchronous active-low reset on the falling edge
    always_ff @(negedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b1;
            tc_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            tc_q    <= tc_d;
            ack_q   <= ack_d;
        end
    end

    // J sets bits that must rise, K clears bits that must fall; idle cycles present zeros
    always_comb begin
        if (bank_en_s) begin
            j_vec = next_val_s & ~count;
            k_vec = ~next_val_s & count;
        end else begin
            j_vec = ZERO;
            k_vec = ZERO;
        end
    end

    modulo_sequenciador_jk_jk_bank #(
        .WIDTH (WIDTH)
    ) u_jk_bank (
        .clk    (clk),
        .rst    (~rst),
        .enable (bank_en_s),
        .j      (j_vec),
        .k      (k_vec),
        .q      (count)
    );

    assign state = state_q;
    assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign tc    = tc_q;

endmodule

// File: tb/tb_modulo_sequenciador_jk.sv
// Directed, table-driven bench for modulo_sequenciador_jk (WIDTH=4, MODULUS=10).
// Inputs are driven just after the rising edge; J/K are checked before the
// falling (active) edge, registered results just after it.
module tb_modulo_sequenciador_jk;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic       cmd_dir;
    logic       step_en;
    logic [3:0] count;
    logic [3:0] j_vec;
    logic [3:0] k_vec;
    logic       busy;
    logic       tc;
    logic [1:0] state;

    localparam logic [1:0] START = 2'b00;
    localparam logic [1:0] STOP  = 2'b01;
    localparam logic [1:0] LOAD  = 2'b10;
    localparam logic [1:0] CLEAR = 2'b11;
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;
    localparam logic [1:0] DONE  = 2'b11;

    int n_tests = 0;
    int n_fail  = 0;

    modulo_sequenciador_jk #(.WIDTH(4), .MODULUS(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_dir   (cmd_dir),
        .step_en   (step_en),
        .count     (count),
        .j_vec     (j_vec),
        .k_vec     (k_vec),
        .busy      (busy),
        .tc        (tc),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic [3:0] data;
        logic       dir;
        logic       step;
        logic [3:0] j;
        logic [3:0] k;
        logic [3:0] cnt;
        logic [1:0] st;
        logic       tcx;
        logic       rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [1:0] op, logic [3:0] data, logic dir,
                                logic step, logic [3:0] j, logic [3:0] k, logic [3:0] cnt,
                                logic [1:0] st, logic tcx, logic rdy);
        vec_t r;
        r.v = v; r.op = op; r.data = data; r.dir = dir; r.step = step;
        r.j = j; r.k = k; r.cnt = cnt; r.st = st; r.tcx = tcx; r.rdy = rdy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] data,
                         input logic dir, input logic step);
        @(posedge clk);
        cmd_valid = v;
        cmd_op    = op;
        cmd_data  = data;
        cmd_dir   = dir;
        step_en   = step;
    endtask

    task automatic after_edge();
        @(negedge clk);
        #1;
    endtask

    initial begin
        //            v  op     dat    dir   stp   j        k        cnt    st     tc rdy
        // count up 0..9 then wrap into DONE
        tbl.push_back(mk(1'b1, START, 4'd0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'd0, RUN,  1'b0, 1'b0));
        tbl.push_back(mk(1'b0, START, 4'd0, 1'b1, 1'b1, 4'b0001, 4'b0000, 4'd1, RUN,  1'b0, 1'b1));
        tbl.push_back(mk(1'b0, START, 4'd0, 1'b1, 1'b1, 4'b0010, 4'b0001, 4'd2, RUN,  1'b0, 1'b1));
        tbl.push_back(mk(1'b0, START, 4'd0, 1'b1, 1'b1, 4'b0001, 4'b0000, 4'd3, RUN,  1'b0, 1'b1));
        tbl.push_back(mk(1'b0, START, 4'd0, 1'b1, 1'b1, 4'b0100, 4'b0011, 4'd4, RUN,  1'b0, 1'b1));
        tbl.push_back(mk(1'b0, START, 4'd0, 1'b1, 1'b1, 4'b0001, 4'b0000, 4'd5, RUN,  1'b0, 1'b1));
        tbl.push_back(mk(1'b0, START, 4'd0, 1'b1, 1'b1, 4'b0010, 4'b0001, 4'd6, RUN,  1'b0, 1'b1));
        tbl.push_back(mk(1'b0, START, 4'd0, 1'b1, 1'b1, 4'b0001, 4'b0000, 4'd7, RUN,  1'b0, 1'b1));
        tbl.push_back(mk(1'b0, START, 4'd0, 1'b1, 1'b1, 4'b1000, 4'b0111, 4'd8, RUN,  1'b0, 1'b1));
        tbl.push_back(mk(1'b0, START, 4'd0, 1'b1, 1'b1, 4'b0001, 4'b0000, 4'd9, RUN,  1'b0, 1'b1));
        tbl.push_back(mk(1'b0, START, 4'd0, 1'b1, 1'b1, 4'b0000, 4'b1001, 4'd0, DONE, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, START, 4'd0, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'd0, DONE, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, CLEAR, 4'd0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'd0, IDLE, 1'b0, 1'b0));
        // valid while ready is low is not taken
        tbl.push_back(mk(1'b1, LOAD,  4'd3, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'd0, IDLE, 1'b0, 1'b1));
        // LOAD 13 clamps to 9, then count down
        tbl.push_back(mk(1'b1, LOAD, 4'd13, 1'b1, 1'b0, 4'b1001, 4'b0000, 4'd9, IDLE, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, START, 4'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd9, IDLE, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, START, 4'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd9, RUN,  1'b0, 1'b0));
        tbl.push_back(mk(1'b0, START, 4'd0, 1'b0, 1'b1, 4'b0000, 4'b0001, 4'd8, RUN,  1'b0, 1'b1));
        tbl.push_back(mk(1'b0, START, 4'd0, 1'b0, 1'b1, 4'b0111, 4'b1000, 4'd7, RUN,  1'b0, 1'b1));
        tbl.push_back(mk(1'b0, START, 4'd0, 1'b0, 1'b1, 4'b0000, 4'b0001, 4'd6, RUN,  1'b0, 1'b1));
        // LOAD beats step on the same edge
        tbl.push_back(mk(1'b1, LOAD,  4'd5, 1'b0, 1'b1, 4'b0001, 4'b0010, 4'd5, RUN,  1'b0, 1'b0));
        tbl.push_back(mk(1'b0, START, 4'd0, 1'b0, 1'b1, 4'b0000, 4'b0001, 4'd4, RUN,  1'b0, 1'b1));
        // STOP pauses, steps ignored, START resumes upward
        tbl.push_back(mk(1'b1, STOP,  4'd0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'd4, PAUSE, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, START, 4'd0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'd4, PAUSE, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, START, 4'd0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'd4, RUN,  1'b0, 1'b0));
        tbl.push_back(mk(1'b0, START, 4'd0, 1'b1, 1'b1, 4'b0001, 4'b0000, 4'd5, RUN,  1'b0, 1'b1));
        tbl.push_back(mk(1'b0, START, 4'd0, 1'b1, 1'b1, 4'b0010, 4'b0001, 4'd6, RUN,  1'b0, 1'b1));
        tbl.push_back(mk(1'b0, START, 4'd0, 1'b1, 1'b1, 4'b0001, 4'b0000, 4'd7, RUN,  1'b0, 1'b1));

        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 4'd0;
        cmd_dir   = 1'b1;
        step_en   = 1'b0;

        // Reset held for two cycles
        after_edge();
        after_edge();
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_state", 32'(state), 32'(IDLE));
        chk("reset_ready", 32'(cmd_ready), 32'd0);
        chk("reset_tc", 32'(tc), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        rst = 1'b1;
        #1;
        chk("release_ready", 32'(cmd_ready), 32'd1);
        after_edge();

        // Table of single-cycle vectors
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].data, tbl[i].dir, tbl[i].step);
            #1;
            chk($sformatf("row%0d_j", i), 32'(j_vec), 32'(tbl[i].j));
            chk($sformatf("row%0d_k", i), 32'(k_vec), 32'(tbl[i].k));
            after_edge();
            chk($sformatf("row%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("row%0d_state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("row%0d_tc", i), 32'(tc), 32'(tbl[i].tcx));
            chk($sformatf("row%0d_ready", i), 32'(cmd_ready), 32'(tbl[i].rdy));
            chk($sformatf("row%0d_busy", i), 32'(busy),
                32'((tbl[i].st == RUN) || (tbl[i].st == PAUSE)));
        end

        // Reset in mid-RUN at count 7 aborts without tc
        drive(1'b0, START, 4'd0, 1'b1, 1'b1);
        rst = 1'b0;
        #1;
        chk("midrst_ready", 32'(cmd_ready), 32'd0);
        chk("midrst_en_j", 32'(j_vec), 32'd0);
        after_edge();
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_state", 32'(state), 32'(IDLE));
        chk("midrst_tc", 32'(tc), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        after_edge();
        chk("midrst_tc2", 32'(tc), 32'd0);
        drive(1'b0, START, 4'd0, 1'b1, 1'b0);
        rst = 1'b1;
        after_edge();
        chk("midrst_release_ready", 32'(cmd_ready), 32'd1);

        // Down wrap 0 -> 9 into DONE, then CLEAR
        drive(1'b1, START, 4'd0, 1'b0, 1'b0);
        after_edge();
        chk("dn_start_state", 32'(state), 32'(RUN));
        drive(1'b0, START, 4'd0, 1'b0, 1'b1);
        #1;
        chk("dn_wrap_j", 32'(j_vec), 32'b1001);
        chk("dn_wrap_k", 32'(k_vec), 32'b0000);
        after_edge();
        chk("dn_wrap_count", 32'(count), 32'd9);
        chk("dn_wrap_state", 32'(state), 32'(DONE));
        chk("dn_wrap_tc", 32'(tc), 32'd1);
        drive(1'b0, START, 4'd0, 1'b0, 1'b0);
        after_edge();
        chk("dn_tc_fall", 32'(tc), 32'd0);
        chk("dn_hold_count", 32'(count), 32'd9);
        drive(1'b1, CLEAR, 4'd0, 1'b0, 1'b0);
        #1;
        chk("clr_k", 32'(k_vec), 32'b1001);
        after_edge();
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_state", 32'(state), 32'(IDLE));
        chk("clr_ready", 32'(cmd_ready), 32'd0);
        drive(1'b0, START, 4'd0, 1'b0, 1'b0);
        after_edge();
        chk("clr_ready_back", 32'(cmd_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
